// File: rtl/axi_lite_slave_dual.sv
// rtl/axi_lite_slave_dual.sv - AXI4-Lite slave with concurrent read/write engines and req/ack user port
//
// Purpose : Bridges an AXI4-Lite master to a held-request / pulsed-ack register
//           interface. The write and read engines are fully independent, so one
//           write and one read can be in flight at the same time. AW and W may
//           arrive in either order. Byte strobes are forwarded unchanged.
// Macro   : AXI_LITE_SLAVE_TIMEOUT_EN - enables a per-channel watchdog that drops
//           a request left unacked for TIMEOUT_CYCLES and answers SLVERR.
// Ports   : clk, rst (sync, active high)
//           AXI-Lite write : i_awvalid/o_awready/i_awaddr, i_wvalid/o_wready/i_wdata/i_wstrb,
//                            o_bvalid/i_bready/o_bresp
//           AXI-Lite read  : i_arvalid/o_arready/i_araddr, o_rvalid/i_rready/o_rdata/o_rresp
//           User write     : o_reg_wr_req/addr/data/strb, i_reg_wr_ack_stb, i_reg_wr_invalid
//           User read      : o_reg_rd_req/addr, i_reg_rd_ack_stb, i_reg_rd_data, i_reg_rd_invalid
module axi_lite_slave_dual #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [STROBE_WIDTH-1:0] i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_reg_wr_req,
  output logic [ADDR_WIDTH-1:0]   o_reg_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_reg_wr_data,
  output logic [STROBE_WIDTH-1:0] o_reg_wr_strb,
  input  logic                    i_reg_wr_ack_stb,
  input  logic                    i_reg_wr_invalid,
  output logic                    o_reg_rd_req,
  output logic [ADDR_WIDTH-1:0]   o_reg_rd_addr,
  input  logic                    i_reg_rd_ack_stb,
  input  logic [DATA_WIDTH-1:0]   i_reg_rd_data,
  input  logic                    i_reg_rd_invalid
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {WR_IDLE, WR_NEED_DATA, WR_NEED_ADDR, WR_USER, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_USER, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  // Every AXI/user output is a flop so that all outputs are 0 while rst is high
  // and the ready signals only rise on the first clock after reset is released.
  logic                    awready_n, wready_n, bvalid_n, wr_req_n;
  logic [1:0]              bresp_n;
  logic [ADDR_WIDTH-1:0]   wr_addr_n;
  logic [DATA_WIDTH-1:0]   wr_data_n;
  logic [STROBE_WIDTH-1:0] wr_strb_n;
  logic                    arready_n, rvalid_n, rd_req_n;
  logic [1:0]              rresp_n;
  logic [ADDR_WIDTH-1:0]   rd_addr_n;
  logic [DATA_WIDTH-1:0]   rdata_n;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = i_awvalid && o_awready;
  assign w_hs  = i_wvalid  && o_wready;
  assign ar_hs = i_arvalid && o_arready;

  logic wr_expire, rd_expire;
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
  // Counter runs only while the engine sits in its USER state and is cleared
  // everywhere else, so it restarts each time a request rises.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  assign wr_expire = (wr_cnt == CNT_LAST);
  assign rd_expire = (rd_cnt == CNT_LAST);
`else
  assign wr_expire = 1'b0;
  assign rd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= WR_IDLE;
      rd_state      <= RD_IDLE;
      o_awready     <= 1'b0;
      o_wready      <= 1'b0;
      o_bvalid      <= 1'b0;
      o_bresp       <= RESP_OKAY;
      o_reg_wr_req  <= 1'b0;
      o_reg_wr_addr <= '0;
      o_reg_wr_data <= '0;
      o_reg_wr_strb <= '0;
      o_arready     <= 1'b0;
      o_rvalid      <= 1'b0;
      o_rresp       <= RESP_OKAY;
      o_rdata       <= '0;
      o_reg_rd_req  <= 1'b0;
      o_reg_rd_addr <= '0;
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
      wr_cnt        <= '0;
      rd_cnt        <= '0;
`endif
    end else begin
      wr_state      <= wr_state_n;
      rd_state      <= rd_state_n;
      o_awready     <= awready_n;
      o_wready      <= wready_n;
      o_bvalid      <= bvalid_n;
      o_bresp       <= bresp_n;
      o_reg_wr_req  <= wr_req_n;
      o_reg_wr_addr <= wr_addr_n;
      o_reg_wr_data <= wr_data_n;
      o_reg_wr_strb <= wr_strb_n;
      o_arready     <= arready_n;
      o_rvalid      <= rvalid_n;
      o_rresp       <= rresp_n;
      o_rdata       <= rdata_n;
      o_reg_rd_req  <= rd_req_n;
      o_reg_rd_addr <= rd_addr_n;
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
      wr_cnt        <= wr_cnt_n;
      rd_cnt        <= rd_cnt_n;
`endif
    end
  end

  // Write engine
  always_comb begin
    wr_state_n = wr_state;
    awready_n  = o_awready;
    wready_n   = o_wready;
    bvalid_n   = o_bvalid;
    bresp_n    = o_bresp;
    wr_req_n   = o_reg_wr_req;
    wr_addr_n  = o_reg_wr_addr;
    wr_data_n  = o_reg_wr_data;
    wr_strb_n  = o_reg_wr_strb;
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
    wr_cnt_n   = '0;
`endif
    case (wr_state)
      WR_IDLE: begin
        awready_n = 1'b1;
        wready_n  = 1'b1;
        if (aw_hs) wr_addr_n = i_awaddr;
        if (w_hs) begin
          wr_data_n = i_wdata;
          wr_strb_n = i_wstrb;
        end
        if (aw_hs && w_hs) begin
          awready_n  = 1'b0;
          wready_n   = 1'b0;
          wr_req_n   = 1'b1;
          wr_state_n = WR_USER;
        end else if (aw_hs) begin
          awready_n  = 1'b0;
          wr_state_n = WR_NEED_DATA;
        end else if (w_hs) begin
          wready_n   = 1'b0;
          wr_state_n = WR_NEED_ADDR;
        end
      end
      WR_NEED_DATA: begin
        if (w_hs) begin
          wr_data_n  = i_wdata;
          wr_strb_n  = i_wstrb;
          wready_n   = 1'b0;
          wr_req_n   = 1'b1;
          wr_state_n = WR_USER;
        end
      end
      WR_NEED_ADDR: begin
        if (aw_hs) begin
          wr_addr_n  = i_awaddr;
          awready_n  = 1'b0;
          wr_req_n   = 1'b1;
          wr_state_n = WR_USER;
        end
      end
      WR_USER: begin
        // An ack on the terminal count still wins over the watchdog.
        if (i_reg_wr_ack_stb) begin
          wr_req_n   = 1'b0;
          bvalid_n   = 1'b1;
          bresp_n    = i_reg_wr_invalid ? RESP_DECERR : RESP_OKAY;
          wr_state_n = WR_RESP;
        end else if (wr_expire) begin
          wr_req_n   = 1'b0;
          bvalid_n   = 1'b1;
          bresp_n    = RESP_SLVERR;
          wr_state_n = WR_RESP;
        end
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
        else begin
          wr_cnt_n = wr_cnt + 1'b1;
        end
`endif
      end
      WR_RESP: begin
        if (i_bready) begin
          bvalid_n   = 1'b0;
          bresp_n    = RESP_OKAY;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
          wr_state_n = WR_IDLE;
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // Read engine
  always_comb begin
    rd_state_n = rd_state;
    arready_n  = o_arready;
    rvalid_n   = o_rvalid;
    rresp_n    = o_rresp;
    rdata_n    = o_rdata;
    rd_req_n   = o_reg_rd_req;
    rd_addr_n  = o_reg_rd_addr;
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
    rd_cnt_n   = '0;
`endif
    case (rd_state)
      RD_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          rd_addr_n  = i_araddr;
          arready_n  = 1'b0;
          rd_req_n   = 1'b1;
          rd_state_n = RD_USER;
        end
      end
      RD_USER: begin
        if (i_reg_rd_ack_stb) begin
          rd_req_n   = 1'b0;
          rvalid_n   = 1'b1;
          rdata_n    = i_reg_rd_data;
          rresp_n    = i_reg_rd_invalid ? RESP_DECERR : RESP_OKAY;
          rd_state_n = RD_RESP;
        end else if (rd_expire) begin
          rd_req_n   = 1'b0;
          rvalid_n   = 1'b1;
          rdata_n    = '0;
          rresp_n    = RESP_SLVERR;
          rd_state_n = RD_RESP;
        end
`ifdef AXI_LITE_SLAVE_TIMEOUT_EN
        else begin
          rd_cnt_n = rd_cnt + 1'b1;
        end
`endif
      end
      RD_RESP: begin
        if (i_rready) begin
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
          rd_state_n = RD_IDLE;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

endmodule
